// File: rtl/ctrl_modulo.sv
// ctrl_modulo: control FSM driving a repeated compare/subtract modulo datapath.
// Reports the quotient, a busy/done handshake and divide-by-zero / limit errors.
module ctrl_modulo #(
  parameter int unsigned  ALU_LAT  = 2,
  parameter int unsigned  W        = 16,
  parameter logic [W-1:0] MAX_ITER = W'(16'hFFFF)
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] zahl2_i,
  input  logic         valid_i,
  output logic [2:0]   alu_mode_o,
  output logic         wren_update_zahlen_o,
  output logic         wren_zahl1_to_erg_o,
  output logic         wren_term_erg_o,
  output logic         wren_res_to_erg_o,
  output logic         erg_to_alu_a_o,
  output logic         zahl2_to_alu_b_o,
  output logic         check_for_termination_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [W-1:0] quotient_o
);

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_CMP = 3'd2;

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_LOAD,
    S_INIT,
    S_CMP_ISSUE,
    S_CMP_WB,
    S_CHECK,
    S_SUB_ISSUE,
    S_SUB_WB,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state;
  state_t         next;
  logic [CW-1:0]  wait_cnt;
  logic [W-1:0]   quot;
  logic           err;
  logic           issue;
  logic           lat_done;

  assign issue    = (state == S_CMP_ISSUE) || (state == S_SUB_ISSUE);
  assign lat_done = (wait_cnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      quot     <= '0;
      err      <= 1'b0;
    end else begin
      state <= next;
      if (issue && !lat_done) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
      // limit is tested in CHECK before this increment, so no wrap
      if (state == S_IDLE && start_i) quot <= '0;
      else if (state == S_SUB_WB)     quot <= quot + 1'b1;
      if (state == S_IDLE && start_i) err <= 1'b0;
      else if (next == S_ERR)         err <= 1'b1;
    end
  end

  always_comb begin
    next                    = state;
    alu_mode_o              = ALU_NOP;
    wren_update_zahlen_o    = 1'b0;
    wren_zahl1_to_erg_o     = 1'b0;
    wren_term_erg_o         = 1'b0;
    wren_res_to_erg_o       = 1'b0;
    erg_to_alu_a_o          = 1'b0;
    zahl2_to_alu_b_o        = 1'b0;
    check_for_termination_o = 1'b0;
    unique case (state)
      S_IDLE: if (start_i) next = S_LATCH;
      S_LATCH: next = (zahl2_i == '0) ? S_ERR : S_LOAD;
      S_LOAD: begin
        wren_update_zahlen_o = 1'b1;
        next                 = S_INIT;
      end
      S_INIT: begin
        wren_zahl1_to_erg_o = 1'b1;
        next                = S_CMP_ISSUE;
      end
      S_CMP_ISSUE: begin
        alu_mode_o       = ALU_CMP;
        erg_to_alu_a_o   = 1'b1;
        zahl2_to_alu_b_o = 1'b1;
        if (lat_done) next = S_CMP_WB;
      end
      S_CMP_WB: begin
        wren_term_erg_o = 1'b1;
        next            = S_CHECK;
      end
      S_CHECK: begin
        check_for_termination_o = 1'b1;
        if (valid_i)               next = S_DONE;
        else if (quot == MAX_ITER) next = S_ERR;
        else                       next = S_SUB_ISSUE;
      end
      S_SUB_ISSUE: begin
        alu_mode_o       = ALU_SUB;
        erg_to_alu_a_o   = 1'b1;
        zahl2_to_alu_b_o = 1'b1;
        if (lat_done) next = S_SUB_WB;
      end
      S_SUB_WB: begin
        wren_res_to_erg_o = 1'b1;
        next              = S_CMP_ISSUE;
      end
      S_DONE:  next = S_IDLE;
      S_ERR:   next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  assign busy_o     = (state != S_IDLE);
  assign done_o     = (state == S_DONE) || (state == S_ERR);
  assign error_o    = err;
  assign quotient_o = quot;

endmodule

// File: tb/tb_ctrl_modulo.sv
// tb_ctrl_modulo: randomized bench for ctrl_modulo with a behavioural datapath
// and an arithmetic reference for quotient, remainder, latency and error.
module tb_ctrl_modulo;
  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] zahl2_i;
  logic         valid_i;
  logic [2:0]   alu_mode_o;
  logic         wren_update_zahlen_o;
  logic         wren_zahl1_to_erg_o;
  logic         wren_term_erg_o;
  logic         wren_res_to_erg_o;
  logic         erg_to_alu_a_o;
  logic         zahl2_to_alu_b_o;
  logic         check_for_termination_o;
  logic         busy_o;
  logic         done_o;
  logic         error_o;
  logic [W-1:0] quotient_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctrl_modulo #(
    .ALU_LAT (LAT),
    .W       (W),
    .MAX_ITER(16'(LIM))
  ) u_dut (
    .clk                    (clk),
    .rst_i                  (rst_i),
    .start_i                (start_i),
    .zahl2_i                (zahl2_i),
    .valid_i                (valid_i),
    .alu_mode_o             (alu_mode_o),
    .wren_update_zahlen_o   (wren_update_zahlen_o),
    .wren_zahl1_to_erg_o    (wren_zahl1_to_erg_o),
    .wren_term_erg_o        (wren_term_erg_o),
    .wren_res_to_erg_o      (wren_res_to_erg_o),
    .erg_to_alu_a_o         (erg_to_alu_a_o),
    .zahl2_to_alu_b_o       (zahl2_to_alu_b_o),
    .check_for_termination_o(check_for_termination_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .error_o                (error_o),
    .quotient_o             (quotient_o)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // behavioural datapath reacting to the controller's flags
  logic [W-1:0] zahl1 = '0;
  logic [W-1:0] dp_z1 = '0;
  logic [W-1:0] dp_z2 = '0;
  logic [W-1:0] erg   = '0;
  logic         term  = 1'b0;
  logic         noise = 1'b0;

  always @(posedge clk) begin
    noise <= 1'($urandom);
    if (wren_update_zahlen_o) begin
      dp_z1 <= zahl1;
      dp_z2 <= zahl2_i;
    end
    if (wren_zahl1_to_erg_o) erg <= dp_z1;
    if (wren_res_to_erg_o)   erg <= erg - dp_z2;
    if (wren_term_erg_o)     term <= (erg < dp_z2);
  end

  assign valid_i = check_for_termination_o ? term : noise;

  logic [3:0]  wrens;
  logic [28:0] outs;
  assign wrens = {wren_update_zahlen_o, wren_zahl1_to_erg_o,
                  wren_term_erg_o, wren_res_to_erg_o};
  assign outs  = {alu_mode_o, wrens, erg_to_alu_a_o, zahl2_to_alu_b_o,
                  check_for_termination_o, busy_o, done_o, error_o,
                  quotient_o};

  // per-cycle protocol watcher; totals are compared per run
  int res_tot = 0, chk_tot = 0, wb_tot = 0;
  int oh_viol = 0, sel_viol = 0, win_viol = 0, stab_viol = 0;

  always @(negedge clk) begin
    static int run = 0;
    static logic [2:0] run_mode = 3'd0;
    if ($countones(wrens) > 1) oh_viol = oh_viol + 1;
    if ({erg_to_alu_a_o, zahl2_to_alu_b_o} != {2{alu_mode_o != 3'd0}})
      sel_viol = sel_viol + 1;
    if (!rst_i) begin
      run = 0;
    end else if (alu_mode_o != 3'd0) begin
      if (run > 0 && alu_mode_o != run_mode) stab_viol = stab_viol + 1;
      run_mode = alu_mode_o;
      run      = run + 1;
    end else if (run > 0) begin
      if (run != LAT) win_viol = win_viol + 1;
      run = 0;
    end
    res_tot = res_tot + int'(wren_res_to_erg_o);
    chk_tot = chk_tot + int'(check_for_termination_o);
    wb_tot  = wb_tot + $countones(wrens);
  end

  task automatic do_run(input logic [W-1:0] z1, input logic [W-1:0] z2,
                        input bit noisy);
    int  q, qe, lat, cyc, busy_bad;
    int  r0, c0, w0, o0, s0, v0, t0;
    bit  err_exp;
    q       = (z2 == '0) ? 0 : int'(z1 / z2);
    err_exp = (z2 == '0) || (q > LIM);
    qe      = (z2 == '0) ? 0 : ((q > LIM) ? LIM : q);
    lat     = (z2 == '0) ? 2
            : 4 + (qe + 1) * (LAT + 2) + qe * (LAT + 1);
    zahl1   = z1;
    zahl2_i = z2;
    r0 = res_tot; c0 = chk_tot; w0 = wb_tot;
    o0 = oh_viol; s0 = sel_viol; v0 = win_viol; t0 = stab_viol;
    busy_bad = 0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (done_o) break;
      if (!busy_o) busy_bad++;
      if (noisy) start_i = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check("latency", 64'(cyc), 64'(lat));
    check("done", 64'(done_o), 64'(1));
    check("busy_in_run", 64'(busy_bad), 64'(0));
    check("busy_at_done", 64'(busy_o), 64'(1));
    check("error", 64'(error_o), 64'(err_exp));
    check("quotient", 64'(quotient_o), 64'(qe));
    if (!err_exp) check("remainder", 64'(erg), 64'(z1 % z2));
    check("sub_wb_count", 64'(res_tot - r0), 64'(qe));
    check("check_count", 64'(chk_tot - c0),
          64'((z2 == '0) ? 0 : qe + 1));
    check("wren_count", 64'(wb_tot - w0),
          64'((z2 == '0) ? 0 : 3 + 2 * qe));
    @(posedge clk); #1;
    check("done_pulse", 64'(done_o), 64'(0));
    check("idle_busy", 64'(busy_o), 64'(0));
    check("error_hold", 64'(error_o), 64'(err_exp));
    check("quot_hold", 64'(quotient_o), 64'(qe));
    check("wren_onehot", 64'(oh_viol - o0), 64'(0));
    check("sel_match", 64'(sel_viol - s0), 64'(0));
    check("alu_window", 64'(win_viol - v0), 64'(0));
    check("mode_stable", 64'(stab_viol - t0), 64'(0));
  endtask

  initial begin
    bit found, seen;
    logic [W-1:0] a, b;
    rst_i   = 1'b0;
    start_i = 1'b1;
    zahl2_i = 16'd5;
    zahl1   = 16'd17;
    repeat (2) @(posedge clk);
    #1 check("reset_outs", 64'(outs), 64'(0));
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("start_after_rst", 64'(busy_o), 64'(1));
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(posedge clk); #1;
    check("reset_again", 64'(outs), 64'(0));
    rst_i = 1'b1;

    do_run(16'd17, 16'd5, 1'b0);
    do_run(16'd3, 16'd5, 1'b0);
    do_run(16'd9, 16'd0, 1'b0);
    do_run(16'd100, 16'd1, 1'b0);
    do_run(16'd20, 16'd5, 1'b0);
    do_run(16'd0, 16'd3, 1'b0);
    do_run(16'd4, 16'd4, 1'b1);
    do_run(16'd17, 16'd5, 1'b1);

    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      a = 16'($urandom_range(0, 32'(b) * 6 + 3));
      do_run(a, b, 1'($urandom_range(0, 1)));
    end

    zahl1   = 16'd100;
    zahl2_i = 16'd7;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (alu_mode_o == 3'd1) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_sub", 64'(found), 64'(1));
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_sub", 64'(outs), 64'(0));
    rst_i = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_o || busy_o) seen = 1'b1;
    end
    check("no_resume", 64'(seen), 64'(0));

    do_run(16'd23, 16'd6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
